// File: rtl/fetch_queue_pkg.sv
// Shared definitions for the RV32 fetch front end: XLEN, NOP encoding,
// fetch FSM states, queue entry layout and PC alignment helper.
package fetch_queue_pkg;

    localparam int unsigned    XLEN = 32;
    localparam logic [XLEN-1:0] NOP  = 32'h0000_0013;

    typedef enum logic [1:0] {
        FQ_IDLE,
        FQ_WAIT,
        FQ_DROP
    } fq_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] ir;
    } fq_entry_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
        return a & ~(XLEN'(3));
    endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Instruction-memory, redirect and decode-side signals of the fetch queue.
// master = fetch_queue side, slave = memory/execute/decode environment.
interface fetch_queue_if #(
    parameter int unsigned DEPTH = 4
);
    import fetch_queue_pkg::*;

    logic                     imem_req;
    logic [XLEN-1:0]          imem_addr;
    logic                     imem_ack;
    logic [XLEN-1:0]          imem_data;
    logic                     br_taken;
    logic [XLEN-1:0]          br_target;
    logic                     dc_valid;
    logic                     dc_ready;
    logic [XLEN-1:0]          dc_pc;
    logic [XLEN-1:0]          dc_ir;
    logic [$clog2(DEPTH):0]   fq_count;

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_data,
        input  br_taken, br_target,
        output dc_valid, dc_pc, dc_ir,
        input  dc_ready,
        output fq_count
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_data,
        output br_taken, br_target,
        input  dc_valid, dc_pc, dc_ir,
        output dc_ready,
        input  fq_count
    );

endinterface

// File: rtl/fetch_queue_sync_fifo.sv
// Synchronous FIFO with synchronous clear, occupancy count and a
// fall-through head (o_data shows the oldest entry whenever !o_empty).
module sync_fifo #(
    parameter  int unsigned WIDTH = 64,
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_empty,
    output logic [CW-1:0]    o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_wptr <= r_wptr + 1'b1;
            if (i_pop)  r_rptr <= r_rptr + 1'b1;
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage has no reset; validity is tracked purely by r_count.
    always_ff @(posedge clk) begin
        if (i_push && !i_clr) r_mem[r_wptr] <= i_data;
    end

    assign o_data  = r_mem[r_rptr];
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule

// File: rtl/fetch_queue.sv
// RV32 fetch front end: sequential PC generation, single-outstanding imem
// requests, FIFO of {pc, instr} to decode, and execute-stage redirects.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic           clk,
    input  logic           rst,
    fetch_queue_if.master  bus
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    fq_state_e       r_state;
    fq_state_e       w_state_nxt;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pc_nxt;
    logic [XLEN-1:0] r_addr;
    logic [XLEN-1:0] w_addr_nxt;
    logic            r_req;
    logic            w_req_nxt;

    logic            w_push;
    logic            w_pop;
    logic            w_empty;
    logic [CW-1:0]   w_count;
    logic [CW:0]     w_occ_nxt;
    logic            w_space;
    logic [XLEN-1:0] w_target;
    logic [XLEN-1:0] w_seq_pc;
    fq_entry_t       w_wr_entry;
    fq_entry_t       w_head;

    assign w_target = word_align(bus.br_target);
    assign w_seq_pc = r_addr + XLEN'(4);

    // A redirect discards both the returning word and the decode pop this cycle.
    assign w_push = (r_state == FQ_WAIT) && bus.imem_ack && !bus.br_taken;
    assign w_pop  = !w_empty && bus.dc_ready && !bus.br_taken;

    assign w_occ_nxt = {1'b0, w_count} + {{CW{1'b0}}, w_push} - {{CW{1'b0}}, w_pop};
    assign w_space   = (w_occ_nxt < (CW+1)'(DEPTH));

    assign w_wr_entry.pc = r_addr;
    assign w_wr_entry.ir = bus.imem_data;

    sync_fifo #(
        .WIDTH ($bits(fq_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (bus.br_taken),
        .i_push  (w_push),
        .i_data  (w_wr_entry),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= FQ_IDLE;
            r_pc    <= RESET_PC;
            r_addr  <= RESET_PC;
            r_req   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_addr  <= w_addr_nxt;
            r_req   <= w_req_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_addr_nxt  = r_addr;
        w_req_nxt   = r_req;
        case (r_state)
            FQ_IDLE: begin
                if (bus.br_taken) begin
                    w_state_nxt = FQ_WAIT;
                    w_req_nxt   = 1'b1;
                    w_addr_nxt  = w_target;
                    w_pc_nxt    = w_target;
                end else if (w_space) begin
                    w_state_nxt = FQ_WAIT;
                    w_req_nxt   = 1'b1;
                    w_addr_nxt  = r_pc;
                end
            end
            FQ_WAIT: begin
                if (bus.br_taken && bus.imem_ack) begin
                    w_addr_nxt = w_target;
                    w_pc_nxt   = w_target;
                end else if (bus.br_taken) begin
                    w_state_nxt = FQ_DROP;
                    w_pc_nxt    = w_target;
                end else if (bus.imem_ack) begin
                    w_pc_nxt = w_seq_pc;
                    if (w_space) begin
                        w_addr_nxt = w_seq_pc;
                    end else begin
                        w_state_nxt = FQ_IDLE;
                        w_req_nxt   = 1'b0;
                    end
                end
            end
            FQ_DROP: begin
                // The FIFO was cleared on entry and nothing is pushed here, so
                // the pending target is always issued once the stale word returns.
                if (bus.imem_ack) begin
                    w_state_nxt = FQ_WAIT;
                    w_req_nxt   = 1'b1;
                    w_addr_nxt  = bus.br_taken ? w_target : r_pc;
                    w_pc_nxt    = bus.br_taken ? w_target : r_pc;
                end else if (bus.br_taken) begin
                    w_pc_nxt = w_target;
                end
            end
            default: begin
                w_state_nxt = FQ_IDLE;
                w_req_nxt   = 1'b0;
            end
        endcase
    end

    assign bus.imem_req  = r_req;
    assign bus.imem_addr = r_addr;
    assign bus.dc_valid  = !w_empty;
    assign bus.dc_pc     = w_empty ? '0  : w_head.pc;
    assign bus.dc_ir     = w_empty ? NOP : w_head.ir;
    assign bus.fq_count  = w_count;

endmodule
